// File: rtl/mem_b_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_b_reader
//  Description : Read-back engine for memory B. On Start, fetches Count
//                consecutive words from address 0 over a 1-cycle-latency
//                synchronous read port and presents each one on a
//                valid/ready stream. Done pulses once the last word is
//                accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_b_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Count,
    output logic [ADDR_W-1:0] AddrB,
    output logic              ReadEnB,
    input  logic [DATA_W-1:0] DataOutB,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Largest transfer length; longer requests are clamped so AddrB never wraps
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W:0]     len_q,   len_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                valid_q, valid_d;
    logic                last_word;

    // Current word is the final one of the transfer
    assign last_word = ({1'b0, addr_q} == (len_q - C_ONE));

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Count != '0) begin
                        len_d   = (Count > C_DEPTH) ? C_DEPTH : Count;
                        addr_d  = '0;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // Read data from memory B is valid in this cycle
                data_d  = DataOutB;
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (DataReady) begin
                    valid_d = 1'b0;
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from registered state
    assign AddrB     = addr_q;
    assign ReadEnB   = (state_q == S_READ);
    assign DataOut   = data_q;
    assign DataValid = valid_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_b_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_b_reader
//  Description : Scoreboard bench for mem_b_reader with a 1-cycle-latency
//                memory B model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_b_reader;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       Start;
    logic [3:0] Count;
    logic [2:0] AddrB;
    logic       ReadEnB;
    logic [7:0] DataOutB;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       DataReady;
    logic       Busy;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [8];
    logic [7:0] exp_data [$];
    logic [2:0] exp_addr [$];
    int         exp_done [$];

    mem_b_reader #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Start     (Start),
        .Count     (Count),
        .AddrB     (AddrB),
        .ReadEnB   (ReadEnB),
        .DataOutB  (DataOutB),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clock = ~Clock;

    // Memory B model: synchronous read, data one cycle after ReadEnB
    always @(posedge Clock) begin
        if (ReadEnB) DataOutB <= mem[AddrB];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: actual=%0h required=none (queue empty)", name, act);
    endtask

    // Monitor: pops expected reads, words and Done pulses as the DUT shows them
    always @(negedge Clock) begin
        if (nReset === 1'b1) begin
            if (ReadEnB) begin
                if (exp_addr.size() == 0) note_unexpected("read_addr", 32'(AddrB));
                else chk("read_addr", 32'(AddrB), 32'(exp_addr.pop_front()));
            end
            if (DataValid && DataReady) begin
                if (exp_data.size() == 0) note_unexpected("word", 32'(DataOut));
                else chk("word", 32'(DataOut), 32'(exp_data.pop_front()));
            end
            if (Done) begin
                if (exp_done.size() == 0) note_unexpected("done_pulse", 32'(Done));
                else void'(exp_done.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_xfer(input logic [3:0] c);
        Start = 1'b1;
        Count = c;
        tick();
        Start = 1'b0;
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_addr"},  32'(AddrB),     32'h0);
        chk({pfx, "_rden"},  32'(ReadEnB),   32'h0);
        chk({pfx, "_dout"},  32'(DataOut),   32'h0);
        chk({pfx, "_valid"}, 32'(DataValid), 32'h0);
        chk({pfx, "_busy"},  32'(Busy),      32'h0);
        chk({pfx, "_done"},  32'(Done),      32'h0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!DataValid && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(DataValid), 32'h1);
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!Done && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(Done), 32'h1);
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(3'(i));
            exp_data.push_back(mem[i]);
        end
        exp_done.push_back(1);
    endtask

    initial begin
        int n;
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h33; mem[3] = 8'h01;
        mem[4] = 8'h5A; mem[5] = 8'hA5; mem[6] = 8'h7E; mem[7] = 8'hC3;
        DataOutB  = 8'h00;
        nReset    = 1'b0;
        Start     = 1'b1;
        Count     = 4'd3;
        DataReady = 1'b0;

        // Reset held two cycles with Start high
        tick();
        tick();
        check_idle("rst");
        nReset = 1'b1;
        Start  = 1'b0;
        tick();
        check_idle("rst_rel");

        // Count=3, consumer always ready: check cycle-level timing
        DataReady = 1'b1;
        expect_words(3);
        start_xfer(4'd3);
        chk("t2_rden_first", 32'(ReadEnB), 32'h1);
        chk("t2_busy", 32'(Busy), 32'h1);
        tick();
        chk("t2_capt_valid", 32'(DataValid), 32'h0);
        tick();
        chk("t2_first_valid", 32'(DataValid), 32'h1);
        chk("t2_first_word", 32'(DataOut), 32'hFF);
        wait_done("t2_done", n);
        chk("t2_valid_to_done_cycles", 32'(n), 32'd7);
        tick();
        chk("t2_busy_after", 32'(Busy), 32'h0);
        chk("t2_done_single", 32'(Done), 32'h0);
        chk("t2_addr_held", 32'(AddrB), 32'h2);

        // Count=2 with a 4-cycle stall on word 0
        DataReady = 1'b0;
        expect_words(2);
        start_xfer(4'd2);
        wait_valid("t3_valid");
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_valid", 32'(DataValid), 32'h1);
            chk("t3_stall_word", 32'(DataOut), 32'hFF);
            chk("t3_stall_rden", 32'(ReadEnB), 32'h0);
            tick();
        end
        DataReady = 1'b1;
        wait_done("t3_done", n);
        tick();

        // Count=0 goes straight to Done
        exp_done.push_back(1);
        start_xfer(4'd0);
        chk("t4_done", 32'(Done), 32'h1);
        chk("t4_rden", 32'(ReadEnB), 32'h0);
        chk("t4_valid", 32'(DataValid), 32'h0);
        tick();
        chk("t4_done_gone", 32'(Done), 32'h0);
        chk("t4_busy", 32'(Busy), 32'h0);

        // Count=9 clamps to 8; a second Start mid-transfer is ignored
        expect_words(8);
        start_xfer(4'd9);
        tick();
        tick();
        tick();
        Start = 1'b1;
        Count = 4'd2;
        tick();
        Start = 1'b0;
        wait_done("t5_done", n);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_idle_busy", 32'(Busy), 32'h0);
        chk("t5_last_addr", 32'(AddrB), 32'h7);

        // Reset while word 1 of 4 is waiting in OUT
        DataReady = 1'b0;
        exp_addr.push_back(3'd0); exp_data.push_back(8'hFF);
        exp_addr.push_back(3'd1);
        start_xfer(4'd4);
        wait_valid("t6_valid0");
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
        wait_valid("t6_valid1");
        chk("t6_word1", 32'(DataOut), 32'h00);
        nReset = 1'b0;
        tick();
        check_idle("t6_rst");
        nReset = 1'b1;
        tick();
        chk("t6_no_done", 32'(Done), 32'h0);
        DataReady = 1'b1;
        expect_words(1);
        start_xfer(4'd1);
        wait_done("t6_done", n);
        for (int i = 0; i < 4; i++) tick();

        chk("left_addr", 32'(exp_addr.size()), 32'd0);
        chk("left_data", 32'(exp_data.size()), 32'd0);
        chk("left_done", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
